// File: rtl/fft_iter.sv
// Iterative radix-2 DIT FFT: bit-reversed load, in-place shared butterfly, natural-order unload.
// Optional macro FFT_SCALE_EN halves every butterfly result so the output is X/N.
module fft_iter #(
  parameter int DATA_CNT   = 32,
  parameter int STAGE_CNT  = $clog2(DATA_CNT),
  parameter int DATA_WIDTH = 32,
  parameter int QBITS      = 14
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [2*DATA_WIDTH-1:0] in_dout,
  input  logic                    in_empty,
  output logic                    in_rd_en,
  input  logic                    re_full,
  input  logic                    im_full,
  output logic [DATA_WIDTH-1:0]   re_din,
  output logic [DATA_WIDTH-1:0]   im_din,
  output logic                    re_wr_en,
  output logic                    im_wr_en,
  output logic                    busy,
  output logic                    frame_done
);
  localparam int W    = DATA_WIDTH;
  localparam int HALF = DATA_CNT / 2;

  localparam logic [STAGE_CNT-1:0] LAST_IDX   = '1;
  localparam logic [STAGE_CNT-1:0] LAST_STAGE = STAGE_CNT'(STAGE_CNT - 1);
  localparam logic [STAGE_CNT-1:0] IDX_ONE    = STAGE_CNT'(1);
  localparam logic [STAGE_CNT-2:0] LAST_BFLY  = '1;
  localparam logic [STAGE_CNT-2:0] BFLY_ONE   = (STAGE_CNT - 1)'(1);
  localparam logic signed [2*W-1:0] RND = {{(2*W-QBITS){1'b0}}, {QBITS{1'b1}}};

  typedef enum logic [1:0] {S_LOAD, S_CALC, S_OUT} state_t;

  state_t                state, state_next;
  logic [STAGE_CNT-1:0]  cnt;
  logic [STAGE_CNT-1:0]  stage;
  logic [STAGE_CNT-2:0]  bfly;

  logic signed [W-1:0] mem_re [DATA_CNT];
  logic signed [W-1:0] mem_im [DATA_CNT];

  logic signed [W-1:0] tw_re [HALF];
  logic signed [W-1:0] tw_im [HALF];

  // Twiddle ROM: W^k = cos - j*sin, rounded to QBITS fraction bits at elaboration.
  for (genvar g = 0; g < HALF; g++) begin : g_tw
    localparam real ANG = 2.0 * 3.14159265358979323846 * g / DATA_CNT;
    localparam int  C   = int'($cos(ANG) * (2.0 ** QBITS));
    localparam int  S   = int'($sin(ANG) * (2.0 ** QBITS));
    assign tw_re[g] = W'(C);
    assign tw_im[g] = W'(-S);
  end

  function automatic logic [STAGE_CNT-1:0] bitrev(input logic [STAGE_CNT-1:0] v);
    logic [STAGE_CNT-1:0] r;
    for (int unsigned i = 0; i < STAGE_CNT; i++) r[i] = v[STAGE_CNT-1-i];
    return r;
  endfunction

  // Signed divide by 2^QBITS truncating toward zero, then keep W bits.
  function automatic logic signed [W-1:0] dequant(input logic signed [2*W-1:0] p);
    logic signed [2*W-1:0] adj;
    adj = p[2*W-1] ? p + RND : p;
    return W'(adj >>> QBITS);
  endfunction

  logic [STAGE_CNT-1:0] b_ext, h, pos, top, bot;
  logic [STAGE_CNT-2:0] k;

  always_comb begin
    b_ext = {1'b0, bfly};
    h     = IDX_ONE << stage;
    pos   = b_ext & (h - IDX_ONE);
    top   = ((b_ext >> stage) << (stage + IDX_ONE)) + pos;
    bot   = top + h;
    k     = (STAGE_CNT - 1)'(pos << (LAST_STAGE - stage));
  end

  logic signed [W-1:0]   a_re, a_im, b_re, b_im, w_re, w_im;
  logic signed [W-1:0]   t_re, t_im, s_re, s_im, d_re, d_im;
  logic signed [2*W-1:0] acc_re, acc_im;

  always_comb begin
    a_re   = mem_re[top];
    a_im   = mem_im[top];
    b_re   = mem_re[bot];
    b_im   = mem_im[bot];
    w_re   = tw_re[k];
    w_im   = tw_im[k];
    acc_re = (2*W)'(w_re) * (2*W)'(b_re) - (2*W)'(w_im) * (2*W)'(b_im);
    acc_im = (2*W)'(w_re) * (2*W)'(b_im) + (2*W)'(w_im) * (2*W)'(b_re);
    t_re   = dequant(acc_re);
    t_im   = dequant(acc_im);
    s_re   = a_re + t_re;
    s_im   = a_im + t_im;
    d_re   = a_re - t_re;
    d_im   = a_im - t_im;
`ifdef FFT_SCALE_EN
    s_re   = s_re >>> 1;
    s_im   = s_im >>> 1;
    d_re   = d_re >>> 1;
    d_im   = d_im >>> 1;
`endif
  end

  // Outputs are gated by reset_n so nothing is requested while reset is held.
  always_comb begin
    state_next = state;
    in_rd_en   = 1'b0;
    re_wr_en   = 1'b0;
    im_wr_en   = 1'b0;
    re_din     = '0;
    im_din     = '0;
    frame_done = 1'b0;
    busy       = reset_n && (state == S_CALC || state == S_OUT);
    case (state)
      S_LOAD: begin
        in_rd_en = reset_n && !in_empty;
        if (in_rd_en && cnt == LAST_IDX) state_next = S_CALC;
      end
      S_CALC: begin
        if (bfly == LAST_BFLY && stage == LAST_STAGE) state_next = S_OUT;
      end
      S_OUT: begin
        re_din     = mem_re[cnt];
        im_din     = mem_im[cnt];
        re_wr_en   = reset_n && !re_full && !im_full;
        im_wr_en   = re_wr_en;
        frame_done = re_wr_en && cnt == LAST_IDX;
        if (frame_done) state_next = S_LOAD;
      end
      default: state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= S_LOAD;
      cnt   <= '0;
      stage <= '0;
      bfly  <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_LOAD: if (in_rd_en) cnt <= cnt + IDX_ONE;
        S_CALC: begin
          bfly <= bfly + BFLY_ONE;
          if (bfly == LAST_BFLY) stage <= (stage == LAST_STAGE) ? '0 : stage + IDX_ONE;
        end
        S_OUT:  if (re_wr_en) cnt <= cnt + IDX_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (in_rd_en) begin
      mem_re[bitrev(cnt)] <= in_dout[2*W-1:W];
      mem_im[bitrev(cnt)] <= in_dout[W-1:0];
    end else if (state == S_CALC) begin
      mem_re[top] <= s_re;
      mem_im[top] <= s_im;
      mem_re[bot] <= d_re;
      mem_im[bot] <= d_im;
    end
  end

endmodule

// File: tb/tb_fft_iter.sv
// Directed self-checking bench for fft_iter (32-point); honours FFT_SCALE_EN for expected values.
`timescale 1ns/1ps
module tb_fft_iter;
  localparam int N = 32;
  localparam int W = 32;
  localparam int Q = 14;
`ifdef FFT_SCALE_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [2*W-1:0] in_dout = '0;
  logic           in_empty = 1'b1;
  logic           in_rd_en;
  logic           re_full = 1'b0;
  logic           im_full = 1'b0;
  logic [W-1:0]   re_din, im_din;
  logic           re_wr_en, im_wr_en, busy, frame_done;

  fft_iter #(.DATA_CNT(N), .DATA_WIDTH(W), .QBITS(Q)) dut (
    .clock(clock), .reset_n(reset_n), .in_dout(in_dout), .in_empty(in_empty),
    .in_rd_en(in_rd_en), .re_full(re_full), .im_full(im_full), .re_din(re_din),
    .im_din(im_din), .re_wr_en(re_wr_en), .im_wr_en(im_wr_en), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic signed [W-1:0] x_re [N], x_im [N], e_re [N], e_im [N];
  logic signed [W-1:0] y_re [$], y_im [$];
  int done_cnt = 0;
  int done_at;

  task automatic check(input string tag, input longint got, input longint exp, input longint tol = 0);
    checks++;
    if (got - exp > tol || exp - got > tol) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      check("wr_pair", re_wr_en, im_wr_en);
      check("wr_while_full", re_wr_en && (re_full || im_full), 0);
      check("rd_on_empty", in_rd_en && in_empty, 0);
      check("rd_while_busy", in_rd_en && busy, 0);
      if (re_wr_en) begin
        y_re.push_back(re_din);
        y_im.push_back(im_din);
      end
      if (frame_done) done_cnt++;
    end
  end

  // Feeds x[] as an FWFT FIFO; abort_at >= 0 stops driving after that many cycles.
  task automatic run_frame(input bit gap, input bit bp, input int abort_at, output int d_at);
    int idx = 0;
    int cyc = 0;
    int full_left = 0;
    bit fired = 1'b0;
    y_re.delete(); y_im.delete();
    done_cnt = 0;
    d_at = 0;
    while (d_at == 0 && cyc < 1000 && cyc != abort_at) begin
      if (idx < N && !(gap && cyc % 2 == 1)) begin
        in_empty = 1'b0;
        in_dout  = {x_re[idx], x_im[idx]};
      end else begin
        in_empty = 1'b1;
        in_dout  = '0;
      end
      if (bp && !fired && y_re.size() == 10) begin
        full_left = 5;
        fired = 1'b1;
      end
      re_full = (full_left > 0);
      @(negedge clock);
      if (in_rd_en) idx++;
      if (frame_done) d_at = cyc + 1;
      if (!gap && cyc == N + 3) check("busy_calc", busy, 1);
      @(posedge clock); #1;
      cyc++;
      if (full_left > 0) full_left--;
    end
    in_empty = 1'b1;
    re_full  = 1'b0;
    if (abort_at < 0) check("timeout", d_at != 0, 1);
  endtask

  task automatic verify(input int tol, input int exp_lat, input int d_at);
    repeat (5) @(posedge clock);
    #1;
    check("n_out", y_re.size(), N);
    check("done_cnt", done_cnt, 1);
    if (exp_lat > 0) check("latency", d_at, exp_lat);
    for (int i = 0; i < N && i < y_re.size(); i++) begin
      check($sformatf("re[%0d]", i), y_re[i], e_re[i], tol);
      check($sformatf("im[%0d]", i), y_im[i], e_im[i], tol);
    end
  endtask

  task automatic set_impulse();
    for (int i = 0; i < N; i++) begin
      x_re[i] = '0; x_im[i] = '0;
      e_re[i] = SCALE ? 32'sh200 : 32'sh4000;
      e_im[i] = '0;
    end
    x_re[0] = 32'sh4000;
  endtask

  task automatic set_dc();
    for (int i = 0; i < N; i++) begin
      x_re[i] = 32'sh100; x_im[i] = '0;
      e_re[i] = '0;       e_im[i] = '0;
    end
    e_re[0] = SCALE ? 32'sh100 : 32'sh2000;
  endtask

  initial begin
    // Reset: outputs held low even with data waiting.
    reset_n  = 1'b0;
    in_empty = 1'b0;
    in_dout  = {32'sh1234, 32'sh5678};
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_rd_en", in_rd_en, 0);
    check("rst_wr_en", re_wr_en | im_wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    @(posedge clock); #1;
    reset_n  = 1'b1;
    in_empty = 1'b1;
    @(negedge clock);
    check("idle_busy", busy, 0);
    check("idle_rd_en", in_rd_en, 0);
    @(posedge clock); #1;

    set_impulse();
    run_frame(1'b0, 1'b0, -1, done_at);
    verify(0, 144, done_at);

    set_dc();
    run_frame(1'b0, 1'b0, -1, done_at);
    verify(0, 144, done_at);

    for (int n = 0; n < N; n++) begin
      x_re[n] = W'(int'(16384.0 * $cos(2.0 * 3.14159265358979323846 * n / N)));
      x_im[n] = '0;
      e_re[n] = '0;
      e_im[n] = '0;
    end
    e_re[1]  = SCALE ? 32'sh2000 : 32'sh40000;
    e_re[31] = SCALE ? 32'sh2000 : 32'sh40000;
    run_frame(1'b0, 1'b0, -1, done_at);
    verify(32, 144, done_at);

    set_dc();
    run_frame(1'b1, 1'b0, -1, done_at);
    verify(0, 0, done_at);

    set_impulse();
    run_frame(1'b0, 1'b1, -1, done_at);
    verify(0, 149, done_at);

    // Abort a DC frame partway through the butterfly phase.
    set_dc();
    run_frame(1'b0, 1'b0, N + 10, done_at);
    check("abort_no_wr", y_re.size(), 0);
    check("abort_no_done", done_cnt, 0);
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    set_impulse();
    run_frame(1'b0, 1'b0, -1, done_at);
    verify(0, 144, done_at);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
